// File: rtl/ws2812_frame_sched.sv
// WS2812 frame sequencer: starts frames from a periodic timer or on request, fetches each
// pixel colour, hands it to the bit serializer, then holds the line idle for the latch gap.
module ws2812_frame_sched #(
  parameter int N_PIXELS     = 64,
  parameter int W_ADDR       = 6,
  parameter int W_DATA       = 24,
  parameter int FRAME_PERIOD = 1666666,
  parameter int LATCH_CYCLES = 30000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_req,
  output logic [W_ADDR-1:0] pix_addr,
  output logic              pix_rd,
  input  logic              pix_ack,
  input  logic [W_DATA-1:0] pix_data,
  output logic [W_DATA-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_idle,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [15:0]       frame_cnt
);

  localparam int W_TMR = $clog2(FRAME_PERIOD + 1);
  localparam int W_LAT = $clog2(LATCH_CYCLES + 1);
  localparam logic [W_ADDR-1:0] LAST_ADDR  = W_ADDR'(N_PIXELS - 1);
  localparam logic [W_TMR-1:0]  LAST_TICK  = W_TMR'(FRAME_PERIOD - 1);
  localparam logic [W_LAT-1:0]  LAST_LATCH = W_LAT'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    DRAIN,
    LATCH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W_TMR-1:0] timer;
  logic [W_LAT-1:0] latch_cnt;
  logic             pending;
  logic             tick;
  logic             start;
  logic             latch_last;

  assign tick       = (timer == LAST_TICK);
  assign start      = (state == IDLE) && ((tick && enable) || frame_req || pending);
  assign latch_last = (latch_cnt == LAST_LATCH);
  // A tick that lands mid-frame is dropped rather than queued; only enabled ticks report it.
  assign overrun    = tick && enable && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pix_rd     = 1'b0;
    tx_valid   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        pix_rd    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (pix_ack) state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = (pix_addr == LAST_ADDR) ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (tx_idle) state_nxt = LATCH;
      end
      LATCH: begin
        if (latch_last) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timer free-runs independent of the FSM so tick spacing never drifts with frame length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      pending   <= 1'b0;
      pix_addr  <= '0;
      tx_data   <= '0;
      latch_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;

      if (start) begin
        pending <= 1'b0;
      end else if (frame_req && (state != IDLE)) begin
        pending <= 1'b1;
      end

      if ((state == WAIT) && pix_ack) begin
        tx_data <= pix_data;
      end

      case (state)
        IDLE:    pix_addr <= '0;
        SEND:    if (tx_ready && (pix_addr != LAST_ADDR)) pix_addr <= pix_addr + 1'b1;
        LATCH:   if (latch_last) pix_addr <= '0;
        default: ;
      endcase

      if (state == DRAIN) begin
        latch_cnt <= '0;
      end else if (state == LATCH) begin
        latch_cnt <= latch_cnt + 1'b1;
      end

      if (frame_done) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched: a slow-period instance for sequencing checks and a
// fast-period instance for dropped-tick behaviour.
module tb_ws2812_frame_sched;

  localparam int NP    = 4;
  localparam int WA    = 2;
  localparam int WD    = 24;
  localparam int LAT_A = 2;
  localparam int LAT_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n = 1'b0, enable = 1'b0, frame_req = 1'b0;
  logic [WA-1:0] pix_addr;
  logic          pix_rd, pix_ack, tx_valid, busy, frame_done, overrun;
  logic [WD-1:0] pix_data, tx_data;
  logic          tx_ready = 1'b1, tx_idle = 1'b1;
  logic [15:0]   frame_cnt;

  logic          src_ack = 1'b0, man_ack = 1'b0;
  logic [WD-1:0] src_data = '0;
  logic [WA-1:0] src_addr = '0;
  int            src_cnt = 0;

  assign pix_ack  = src_ack | man_ack;
  assign pix_data = man_ack ? 24'hDEAD00 : src_data;

  ws2812_frame_sched #(
    .N_PIXELS(NP), .W_ADDR(WA), .W_DATA(WD), .FRAME_PERIOD(200), .LATCH_CYCLES(10)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_req(frame_req),
    .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_ack(pix_ack), .pix_data(pix_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idle(tx_idle),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  logic          rst_b_n = 1'b0;
  logic          enable_b = 1'b1, frame_req_b = 1'b0;
  logic [WA-1:0] pix_addr_b;
  logic          pix_rd_b, tx_valid_b, busy_b, frame_done_b, overrun_b;
  logic [WD-1:0] tx_data_b;
  logic [15:0]   frame_cnt_b;
  logic          srcb_ack = 1'b0;
  logic [WD-1:0] pix_data_b = 24'h55AA55;
  logic          tx_ready_b = 1'b1, tx_idle_b = 1'b1;
  int            srcb_cnt = 0, ovb_cnt = 0, dnb_cnt = 0;

  ws2812_frame_sched #(
    .N_PIXELS(NP), .W_ADDR(WA), .W_DATA(WD), .FRAME_PERIOD(20), .LATCH_CYCLES(10)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .enable(enable_b), .frame_req(frame_req_b),
    .pix_addr(pix_addr_b), .pix_rd(pix_rd_b), .pix_ack(srcb_ack), .pix_data(pix_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_idle(tx_idle_b),
    .busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b), .frame_cnt(frame_cnt_b)
  );

  int            idle_cnt = 0, stall_left = 0, stall_addr = -1, stall_seen = 0, stall_bad = 0;
  logic [WD-1:0] stall_ref = '0;
  int            ov_cnt = 0;
  int            rd_cyc_q[$];
  int            rd_addr_q[$];
  logic [WD-1:0] acc_q[$];
  int            acc_cyc_q[$];
  int            done_q[$];

  // Colour source, serializer and event log for the main instance, all at the falling edge.
  always @(negedge clk) begin : model_a
    logic [7:0] b;
    src_ack = 1'b0;
    if (src_cnt > 0) begin
      src_cnt--;
      if (src_cnt == 0) begin
        b        = 8'hA0 + 8'(src_addr);
        src_data = {b, b, b};
        src_ack  = 1'b1;
      end
    end
    if (pix_rd) begin
      src_cnt  = LAT_A;
      src_addr = pix_addr;
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(int'(pix_addr));
    end
    if (idle_cnt > 0) begin
      idle_cnt--;
      if (idle_cnt == 0) tx_idle = 1'b1;
    end
    tx_ready = 1'b1;
    if (tx_valid && stall_left > 0 && int'(pix_addr) == stall_addr) begin
      if (stall_seen == 0) stall_ref = tx_data;
      else if (tx_data !== stall_ref) stall_bad++;
      stall_seen++;
      stall_left--;
      tx_ready = 1'b0;
    end
    if (tx_valid && tx_ready) begin
      acc_q.push_back(tx_data);
      acc_cyc_q.push_back(cyc);
      idle_cnt = 3;
      tx_idle  = 1'b0;
    end
    if (frame_done) done_q.push_back(cyc);
    if (overrun) ov_cnt++;
  end

  always @(negedge clk) begin : model_b
    srcb_ack = 1'b0;
    if (srcb_cnt > 0) begin
      srcb_cnt--;
      if (srcb_cnt == 0) srcb_ack = 1'b1;
    end
    if (pix_rd_b) srcb_cnt = LAT_B;
    if (overrun_b) ovb_cnt++;
    if (frame_done_b) dnb_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus();
    frame_req = 1'b1;
    waitCycles(1);
    frame_req = 1'b0;
  endtask

  task automatic clearLogs();
    rd_cyc_q.delete();
    rd_addr_q.delete();
    acc_q.delete();
    acc_cyc_q.delete();
    done_q.delete();
    ov_cnt = 0;
  endtask

  task automatic waitFrames(input string tag, input int target, input int limit);
    int n = 0;
    while (done_q.size() < target && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, done_q.size(), target);
  endtask

  function automatic int rdCyc(input int i);
    return (i < rd_cyc_q.size()) ? rd_cyc_q[i] : -1;
  endfunction
  function automatic int rdAddr(input int i);
    return (i < rd_addr_q.size()) ? rd_addr_q[i] : -1;
  endfunction
  function automatic int accCyc(input int i);
    return (i < acc_cyc_q.size()) ? acc_cyc_q[i] : -1;
  endfunction
  function automatic logic [WD-1:0] accData(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 24'hxxxxxx;
  endfunction
  function automatic int doneCyc(input int i);
    return (i < done_q.size()) ? done_q[i] : -1;
  endfunction
  function automatic logic [WD-1:0] colour(input int i);
    logic [7:0] b;
    b = 8'hA0 + 8'(i);
    return {b, b, b};
  endfunction

  int rel, t0, tk;

  initial begin
    enable = 1'b1;
    waitCycles(3);
    checkOutput("rst_ctrl", {pix_rd, tx_valid, busy, frame_done, overrun, pix_addr}, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);

    // Timer-triggered first frame
    rst_n = 1'b1;
    rel   = cyc;
    waitFrames("t1_done", 1, 400);
    checkOutput("t1_first_rd_latency", rdCyc(0) - rel, 200);
    checkOutput("t1_rd_count", rd_cyc_q.size(), NP);
    for (int i = 0; i < NP; i++) begin
      checkOutput($sformatf("t1_addr%0d", i), rdAddr(i), i);
      checkOutput($sformatf("t1_data%0d", i), accData(i), colour(i));
    end
    checkOutput("t1_drain_latch", doneCyc(0) - accCyc(3), 13);
    checkOutput("t1_frame_cnt", frame_cnt, 1);
    checkOutput("t1_busy_after", busy, 0);

    // On-demand frame with ticks disabled
    enable = 1'b0;
    clearLogs();
    waitCycles(2);
    t0 = cyc;
    applyStimulus();
    waitFrames("t2_done", 1, 200);
    checkOutput("t2_req_latency", rdCyc(0) - t0, 1);
    checkOutput("t2_first_addr", rdAddr(0), 0);
    checkOutput("t2_tx_count", acc_q.size(), NP);
    checkOutput("t2_drain_latch", doneCyc(0) - accCyc(3), 13);
    checkOutput("t2_frame_cnt", frame_cnt, 2);
    waitCycles(220);
    checkOutput("t2_silent_overrun", ov_cnt, 0);
    checkOutput("t2_no_tick_frame", rd_cyc_q.size(), NP);

    // Serializer back-pressure on pixel 2
    clearLogs();
    stall_addr = 2;
    stall_left = 5;
    stall_seen = 0;
    stall_bad  = 0;
    applyStimulus();
    waitFrames("t3_done", 1, 200);
    checkOutput("t3_stall_cycles", stall_seen, 5);
    checkOutput("t3_data_stable", stall_bad, 0);
    checkOutput("t3_data2", accData(2), colour(2));
    checkOutput("t3_accept_delay", accCyc(2) - rdCyc(2), 8);
    checkOutput("t3_rd3_after_accept", rdCyc(3) - accCyc(2), 1);
    checkOutput("t3_tx_count", acc_q.size(), NP);
    checkOutput("t3_frame_cnt", frame_cnt, 3);

    // Request during LATCH is held and replayed after one IDLE cycle
    clearLogs();
    t0 = cyc;
    applyStimulus();
    waitCycles(22);
    applyStimulus();
    waitFrames("t5_done", 2, 300);
    checkOutput("t5_first_done", doneCyc(0), t0 + 29);
    checkOutput("t5_pending_gap", rdCyc(4) - doneCyc(0), 2);
    checkOutput("t5_pending_addr", rdAddr(4), 0);
    checkOutput("t5_frame_cnt", frame_cnt, 5);

    // Tick and request in the same IDLE cycle start one frame
    clearLogs();
    tk = rel + 199;
    while (tk < cyc + 5) tk += 200;
    waitCycles(tk - cyc);
    enable    = 1'b1;
    frame_req = 1'b1;
    waitCycles(1);
    frame_req = 1'b0;
    enable    = 1'b0;
    waitFrames("t5_tick_req_done", 1, 200);
    waitCycles(20);
    checkOutput("t5_tick_req_start", rdCyc(0), tk + 1);
    checkOutput("t5_single_frame_rd", rd_cyc_q.size(), NP);
    checkOutput("t5_single_frame_done", done_q.size(), 1);
    checkOutput("t5_frame_cnt2", frame_cnt, 6);

    // Reset in the middle of pixel 1's fetch
    clearLogs();
    t0 = cyc;
    applyStimulus();
    waitCycles(5);
    checkOutput("t6_in_wait", {busy, tx_valid, pix_rd, pix_addr}, {1'b1, 1'b0, 1'b0, 2'd1});
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ctrl", {pix_rd, tx_valid, busy, frame_done, overrun, pix_addr}, 0);
    checkOutput("t6_rst_tx_data", tx_data, 0);
    checkOutput("t6_rst_frame_cnt", frame_cnt, 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
    man_ack = 1'b1;
    waitCycles(1);
    man_ack = 1'b0;
    waitCycles(20);
    checkOutput("t6_late_ack_rd", rd_cyc_q.size(), 2);
    checkOutput("t6_late_ack_busy", {busy, tx_valid}, 0);
    checkOutput("t6_late_ack_data", tx_data, 0);
    checkOutput("t6_no_done", done_q.size(), 0);
    checkOutput("t6_frame_cnt", frame_cnt, 0);

    // Fast timer, slow source: mid-frame ticks are dropped
    rst_b_n = 1'b1;
    waitCycles(150);
    checkOutput("t4_overruns", ovb_cnt, 4);
    checkOutput("t4_frames", dnb_cnt, 2);
    checkOutput("t4_frame_cnt", frame_cnt_b, 2);
    checkOutput("t4_last_data", tx_data_b, 24'h55AA55);
    checkOutput("t4_third_frame", {busy_b, tx_valid_b, pix_addr_b}, {1'b1, 1'b0, 2'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_sched.md
Name: ws2812_frame_sched

Overview:
Frame sequencer for the WS2812 LED matrix chain. It triggers frames from a periodic timer or an on-demand request, and fetches each pixel colour from the colour source over a read-strobe/ack port. It feeds each colour to the bit serializer over a valid/ready port, then enforces the reset/latch gap before the next frame. It sits between the colour generator/framebuffer and the serializer; neither side has to track frame timing.

Parameters:
N_PIXELS, 64, pixels per frame (addresses 0..N_PIXELS-1)
W_ADDR, 6, pixel address width; must satisfy 2**W_ADDR >= N_PIXELS
W_DATA, 24, colour word width
FRAME_PERIOD, 1666666, clk cycles between timer ticks (60 Hz at 100 MHz)
LATCH_CYCLES, 30000, clk cycles of line-idle latch gap after the last bit (300 us at 100 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allows timer-triggered frames
frame_req  in  1  single-cycle request for an immediate frame
pix_addr  out  W_ADDR  pixel address being fetched
pix_rd  out  1  one-cycle read strobe to the colour source
pix_ack  in  1  colour source: pix_data valid this cycle
pix_data  in  W_DATA  colour word
tx_data  out  W_DATA  colour word to the serializer
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  serializer accepts the word when tx_valid is also high
tx_idle  in  1  serializer has finished shifting all bits
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at the end of the latch gap
overrun  out  1  one-cycle pulse when a timer tick is dropped
frame_cnt  out  16  completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, rst_n=0) sets:
  - state IDLE and pix_addr=0;
  - pix_rd, tx_valid, busy, frame_done and overrun to 0;
  - tx_data=0 and frame_cnt=0;
  - period timer=0 and pending=0.
- Period timer: free-runs 0..FRAME_PERIOD-1 whenever out of reset, regardless of state and enable. A tick is the cycle when timer==FRAME_PERIOD-1.
- Trigger: in IDLE, (tick && enable) || frame_req || pending starts a frame.
  - pending clears on frame start.
  - Simultaneous tick and frame_req produce exactly one frame.
- States:
  - IDLE: on trigger -> FETCH with pix_addr=0.
  - FETCH: pix_rd=1 for exactly this cycle -> WAIT.
  - WAIT: on pix_ack, register pix_data into tx_data, set tx_valid=1 -> SEND. Earliest ack is the cycle after pix_rd; any latency is allowed. pix_ack outside WAIT is ignored.
  - SEND: tx_valid=1 and tx_data stable. On the tx_valid && tx_ready cycle, tx_valid drops next cycle.
    - If pix_addr==N_PIXELS-1 -> DRAIN.
    - Otherwise pix_addr+1 -> FETCH.
  - DRAIN: wait for tx_idle=1 -> LATCH, with latch counter=0.
  - LATCH: count LATCH_CYCLES cycles. On the final cycle, pulse frame_done, increment frame_cnt, -> IDLE, pix_addr=0.
- Latency: trigger in cycle T gives pix_rd=1 with pix_addr=0 in cycle T+1.
- Timer tick while not IDLE and enable=1: tick is dropped and overrun pulses in that cycle. No queued frame results.
- frame_req while not IDLE: sets pending. The next frame starts in the cycle after returning to IDLE (one IDLE cycle between frames).
- enable deasserted mid-frame: the current frame completes normally. Subsequent ticks are ignored silently, with no overrun. frame_req is still honoured.
- Reset mid-frame: immediate return to reset values. The serializer sees tx_valid drop asynchronously. No frame_done.
- busy=1 from FETCH entry through the last LATCH cycle.

Test Plan:
Use N_PIXELS=4, FRAME_PERIOD=200, LATCH_CYCLES=10, colour source ack latency 2, tx_ready always 1, tx_idle 3 cycles after last accept.
1. Release reset, enable=1 -> first frame starts at the tick in cycle 199. pix_addr sequence 0,1,2,3 with one pix_rd each; tx_data matches source words 0xA0A0A0..0xA3A3A3; frame_done pulses once; frame_cnt=1.
2. enable=0, frame_req pulse in IDLE -> pix_rd with pix_addr=0 the next cycle. Exactly 4 tx transfers, then DRAIN, then 10 LATCH cycles before frame_done.
3. tx_ready held low 5 cycles on pixel 2 -> tx_valid stays high and tx_data is unchanged throughout. pix_rd for pixel 3 is not issued until after the accept.
4. FRAME_PERIOD=20 with slow source (ack latency 10) -> overrun pulses on each tick during a frame. No back-to-back extra frames; frame_cnt counts only completed frames.
5. frame_req during LATCH -> pending set. The next frame's FETCH occurs exactly 2 cycles after the frame_done cycle; tick and frame_req in the same IDLE cycle yield one frame.
6. rst_n low during WAIT of pixel 1 -> all outputs 0 immediately and frame_cnt=0. A late pix_ack after reset release is ignored.
